// File: rtl/axi_res_tbl_ctrl_pkg.sv
// Shared types for the exclusive-access reservation table controller.
package axi_res_tbl_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam int unsigned STARVE_CNT_W = 8;
  typedef logic [STARVE_CNT_W-1:0] starve_cnt_t;

  function automatic starve_cnt_t sat_inc(input starve_cnt_t cnt, input starve_cnt_t lim);
    return (cnt >= lim) ? lim : starve_cnt_t'(cnt + 1'b1);
  endfunction

endpackage

// File: rtl/axi_res_tbl_ctrl.sv
// Arbitrates write check/clear and LR set accesses to a sibling reservation
// table and returns exclusive-write results over a valid/ready channel.
module axi_res_tbl_ctrl
  import axi_res_tbl_ctrl_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 0,
  parameter int unsigned AXI_ID_WIDTH   = 0,
  parameter int unsigned MAX_SET_WAIT   = 4,
  localparam int unsigned AW = (AXI_ADDR_WIDTH > 0) ? AXI_ADDR_WIDTH : 1,
  localparam int unsigned IW = (AXI_ID_WIDTH > 0) ? AXI_ID_WIDTH : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,

  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [IW-1:0] wr_id_i,
  input  logic          wr_excl_i,

  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic          res_ok_o,
  output logic [IW-1:0] res_id_o,

  input  logic          lr_valid_i,
  output logic          lr_ready_o,
  input  logic [AW-1:0] lr_addr_i,
  input  logic [IW-1:0] lr_id_i,

  output logic          tbl_check_clr_req_o,
  input  logic          tbl_check_clr_gnt_i,
  output logic [AW-1:0] tbl_check_clr_addr_o,
  output logic [IW-1:0] tbl_check_id_o,
  output logic          tbl_check_clr_excl_o,
  input  logic          tbl_check_res_i,

  output logic          tbl_set_req_o,
  input  logic          tbl_set_gnt_i,
  output logic [AW-1:0] tbl_set_addr_o,
  output logic [IW-1:0] tbl_set_id_o
);

  state_e      state_q;
  starve_cnt_t starve_cnt_q;
  logic        starve;
  logic        check_req;
  logic        set_req;
  logic        wr_accept;

  assign tbl_check_clr_addr_o = wr_addr_i;
  assign tbl_check_id_o       = wr_id_i;
  assign tbl_check_clr_excl_o = wr_excl_i;
  assign tbl_set_addr_o       = lr_addr_i;
  assign tbl_set_id_o         = lr_id_i;

  assign starve    = (starve_cnt_q == starve_cnt_t'(MAX_SET_WAIT));
  // A held, unreleased result blocks new checks so it cannot be overwritten.
  assign check_req = wr_valid_i && !starve && ((state_q == IDLE) || res_ready_i);
  assign set_req   = lr_valid_i && !check_req;
  assign wr_accept = check_req && tbl_check_clr_gnt_i;

  // Port-level requests and readies are forced low while reset is asserted.
  assign tbl_check_clr_req_o = rst_ni && check_req;
  assign tbl_set_req_o       = rst_ni && set_req;
  assign wr_ready_o          = rst_ni && tbl_check_clr_gnt_i;
  assign lr_ready_o          = rst_ni && tbl_set_gnt_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      res_valid_o <= 1'b0;
      res_ok_o    <= 1'b0;
      res_id_o    <= '0;
    end else begin
      if (wr_accept && wr_excl_i) begin
        state_q     <= RESP;
        res_valid_o <= 1'b1;
        res_ok_o    <= tbl_check_res_i;
        res_id_o    <= wr_id_i;
      end else if ((state_q == RESP) && res_ready_i) begin
        state_q     <= IDLE;
        res_valid_o <= 1'b0;
      end
    end
  end

  // Counts consecutive cycles an LR waits; reaching the limit forces it through.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
    end else if (lr_valid_i && !tbl_set_gnt_i) begin
      starve_cnt_q <= sat_inc(starve_cnt_q, starve_cnt_t'(MAX_SET_WAIT));
    end else begin
      starve_cnt_q <= '0;
    end
  end

  param_range_a: assert property (@(posedge clk_i)
    (AXI_ADDR_WIDTH > 0) && (AXI_ID_WIDTH > 0) && (MAX_SET_WAIT >= 1) && (MAX_SET_WAIT <= 255));

  res_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (res_valid_o && !res_ready_i) |=> (res_valid_o && $stable(res_ok_o) && $stable(res_id_o)));

endmodule
